serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder.
- Accepts two operands on a start pulse and processes one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop.
- Presents a registered sum and carry-out with a one-cycle done pulse.
- Sits downstream of the one-bit adder cells and serves as the area-minimal arithmetic stage for multi-bit operands.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only when busy=0.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- busy  output  1  high while bits are being processed.
- done  output  1  single-cycle pulse; sum and cout are valid and updated.
- sum  output  WIDTH  registered result, low WIDTH bits of a+b.
- cout  output  1  registered carry-out (bit WIDTH of a+b).

Behaviour:
- Reset: one clock and reset; reset is asynchronous, active-low (rst_n), all flops cleared immediately on assertion. Reset values:
  - state = IDLE
  - busy = 0, done = 0, sum = 0, cout = 0
  - internal shift registers, carry flop and bit counter = 0
- Reset mid-operation aborts the addition; no done pulse for the aborted operation. After release, the block is in IDLE.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at a rising edge: load a/b into operand shift registers, clear the carry flop and bit counter, go to SHIFT.
  - start=0: stay.
- SHIFT:
  - Each edge: full_adder(opA[0], opB[0], carry) -> s, c.
  - carry <= c; result shift register shifts right with s into its MSB; opA and opB shift right; counter increments.
  - When counter == WIDTH-1 at the edge, go to DONE. Load sum <= final result (including this edge's s) and cout <= c.
- DONE:
  - done=1 for exactly this cycle; busy=0.
  - start=1 at this edge is accepted (back-to-back): load as in IDLE, go to SHIFT.
  - Otherwise go to IDLE.
- busy=1 exactly in SHIFT. done=1 exactly in DONE.
- start while busy=1 is ignored; no queuing, no effect on the operation in progress.
- Timing: start sampled at edge 0 -> busy high for cycles 1..WIDTH -> done high in cycle WIDTH+1. Throughput is one addition per WIDTH+1 cycles.
- Holding rules:
  - sum/cout change only on the SHIFT->DONE transition and hold otherwise, including during a following operation.
  - a/b are don't-care after the accepted start edge.
- Arithmetic: {cout,sum} == a + b, modulo 2^(WIDTH+1). No signed interpretation.
- WIDTH=1: one SHIFT cycle, done in cycle 2.
- Bit counter width: clog2(WIDTH) bits, minimum 1.

Decomposition:
- Package serial_adder_pkg:
  - state encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
  - default WIDTH constant.
- Sub-module full_adder: combinational, inputs x, y, cin; outputs s = x^y^cin and co = majority(x,y,cin). It is the only arithmetic in the block.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, start at edge 0 -> busy cycles 1..8, done only in cycle 9, sum=0x08, cout=0.
- a=0xFF, b=0x01 -> sum=0x00, cout=1; a=0xFF, b=0xFF -> sum=0xFE, cout=1; a=0x00, b=0x00 -> sum=0x00, cout=0.
- a=0x10, b=0x20 started; start pulsed with a=0xAA, b=0x55 at cycle 4 (busy) -> ignored, done in cycle 9 with sum=0x30; sum stays 0x30 until next done.
- Back-to-back: start held high continuously with a=0x7F, b=0x01 then a=0x01, b=0x01 -> done in cycles 9 and 18, sum 0x80 then 0x02, cout=0 both.
- rst_n low in cycle 5 of an operation -> busy, done, sum, cout = 0 immediately, no done pulse; after release, new start with 0x0C+0x0C -> done in cycle 9 after start, sum=0x18.
- Randomised 1000 operands, WIDTH=1, 8 and 32 -> {cout,sum} equals a+b every time; done is a single cycle; busy and done are never high together.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding, default width
// and the bit-counter sizing helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Counter must index 0..w-1 but never collapse to zero bits.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full-adder cell; the only arithmetic in the serial adder.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ cin;
    assign co = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first,
// with a registered sum/carry-out and a one-cycle done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_r;
    state_e           state_n;
    logic [WIDTH-1:0] opa_r;
    logic [WIDTH-1:0] opb_r;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] res_shift_s;
    logic [WIDTH:0]   res_ext_s;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;
    logic             fa_s;
    logic             fa_c;
    logic             last_s;

    full_adder u_fa (
        .x   (opa_r[0]),
        .y   (opb_r[0]),
        .cin (carry_r),
        .s   (fa_s),
        .co  (fa_c)
    );

    // New sum bit enters at the MSB; this form also holds for WIDTH=1.
    assign res_ext_s   = {fa_s, res_r};
    assign res_shift_s = res_ext_s[WIDTH:1];
    assign last_s      = (cnt_r == CW'(WIDTH - 1));

    // Next-state decode; the unused encoding recovers to IDLE.
    always_comb begin
        state_n = IDLE;
        case (state_r)
            IDLE: begin
                if (start) state_n = SHIFT;
                else       state_n = IDLE;
            end
            SHIFT: begin
                if (last_s) state_n = DONE;
                else        state_n = SHIFT;
            end
            DONE: begin
                if (start) state_n = SHIFT;
                else       state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            busy_r  <= (state_n == SHIFT);
            done_r  <= (state_n == DONE);
        end
    end

    // Operand/result shifting, carry, bit counter and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_r   <= {WIDTH{1'b0}};
            opb_r   <= {WIDTH{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        opa_r   <= a;
                        opb_r   <= b;
                        res_r   <= {WIDTH{1'b0}};
                        cnt_r   <= {CW{1'b0}};
                        carry_r <= 1'b0;
                    end else begin
                        opa_r   <= opa_r;
                        opb_r   <= opb_r;
                    end
                end
                SHIFT: begin
                    opa_r   <= opa_r >> 1'b1;
                    opb_r   <= opb_r >> 1'b1;
                    res_r   <= res_shift_s;
                    carry_r <= fa_c;
                    cnt_r   <= cnt_r + CW'(1);
                    if (last_s) begin
                        sum_r  <= res_shift_s;
                        cout_r <= fa_c;
                    end else begin
                        sum_r  <= sum_r;
                        cout_r <= cout_r;
                    end
                end
                default: begin
                    carry_r <= 1'b0;
                    cnt_r   <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule
